nec_stack_sequencer: RTL and testbench

//  Consumer of the pre-decoder's push/pop bitmasks (pre_decode_t.push/.pop, STACK_* bit layout).

---
 rtl/nec_stack_sequencer_pkg.sv | 41 ++++
 rtl/nec_stack_sequencer_if.sv | 37 +++
 rtl/nec_stack_sequencer_mask_pick.sv | 32 +++
 rtl/nec_stack_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_nec_stack_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nec_stack_sequencer_pkg.sv
// nec_stack_sequencer_pkg
// Shared types and constants for the stack sequencer slice.
//   stack_seq_state_e : sequencer FSM states
//   STACK_SP_BIT      : bit index of the SP item within the STACK_* masks
//   STACK_*           : one-hot item masks, as produced by the pre-decoder
//   clear_bit()       : removes one item from a mask
package nec_stack_sequencer_pkg;

    typedef enum logic [1:0] {
        SSQ_IDLE,
        SSQ_PUSH,
        SSQ_POP,
        SSQ_FIN
    } stack_seq_state_e;

    localparam int STACK_SP_BIT = 4;

    // Item layout. The ascending index order is also the push order, so
    // AW goes first, and the interrupt frame goes PSW, PS, then PC.
    localparam logic [15:0] STACK_AW    = 16'h0001;
    localparam logic [15:0] STACK_CW    = 16'h0002;
    localparam logic [15:0] STACK_DW    = 16'h0004;
    localparam logic [15:0] STACK_BW    = 16'h0008;
    localparam logic [15:0] STACK_SP    = 16'h0010;
    localparam logic [15:0] STACK_BP    = 16'h0020;
    localparam logic [15:0] STACK_IX    = 16'h0040;
    localparam logic [15:0] STACK_IY    = 16'h0080;
    localparam logic [15:0] STACK_DS1   = 16'h0100;
    localparam logic [15:0] STACK_PSW   = 16'h0200;
    localparam logic [15:0] STACK_PS    = 16'h0400;
    localparam logic [15:0] STACK_SS    = 16'h0800;
    localparam logic [15:0] STACK_DS0   = 16'h1000;
    localparam logic [15:0] STACK_PC    = 16'h2000;
    localparam logic [15:0] STACK_MODRM = 16'h4000;
    localparam logic [15:0] STACK_IMM   = 16'h8000;

    function automatic logic [15:0] clear_bit(input logic [15:0] mask, input logic [3:0] idx);
        return mask & ~(16'h0001 << idx);
    endfunction

endpackage

// File: rtl/nec_stack_sequencer_if.sv
// nec_stack_sequencer_if
// Word-wide stack memory bus between the stack sequencer and the BIU.
//   mem_req   : request, held until acknowledged
//   mem_wr    : 1 = write (push), 0 = read (pop)
//   mem_addr  : physical word address
//   mem_wdata : write data
//   mem_ack   : one-cycle completion strobe
//   mem_rdata : read data, valid with mem_ack
// Modports: master (sequencer side), slave (BIU side).
interface nec_stack_sequencer_if #(
    parameter int ADDR_W = 20
);
    logic              mem_req;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/nec_stack_sequencer_mask_pick.sv
// nec_mask_pick
// Combinational find-first-set over a 16-bit item mask.
//   LSB_FIRST = 1 : index of the lowest set bit
//   LSB_FIRST = 0 : index of the highest set bit
// Ports:
//   mask  in  16  item mask
//   index out 4   selected bit index (0 when mask is empty)
//   any   out 1   mask has at least one bit set
module nec_mask_pick #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic [15:0] mask,
    output logic [3:0]  index,
    output logic        any
);

    // The scan runs towards the preferred end so the last hit wins.
    always_comb begin
        index = 4'd0;
        any   = |mask;
        if (LSB_FIRST) begin
            for (int i = 15; i >= 0; i--) begin
                if (mask[i]) index = 4'(i);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (mask[i]) index = 4'(i);
            end
        end
    end

endmodule

// File: rtl/nec_stack_sequencer.sv
// nec_stack_sequencer
// Expands a push/pop mask pair into an ordered series of word-wide stack
// transactions at SS:SP, tracks SP, and returns popped words to the
// register file. Pushes run in ascending bit order, pops in descending
// order, and all pushes finish before the first pop.
// Ports:
//   clk, reset        core clock, asynchronous active-high reset
//   start             one-cycle request, ignored while a sequence runs
//   push_mask/pop_mask items to push/pop, sampled with start
//   sp_in, ss_in      SP and SS at start
//   busy              sequence in progress
//   done, sp_we       one-cycle pulse after the last transaction; commit sp_out
//   reg_rd_sel        register-file read select for the current push item
//   reg_rd_data       register-file read data (combinational)
//   bus               stack memory bus (master side)
//   wb_valid/sel/data popped word returned to the register file
//   sp_out            working SP
module nec_stack_sequencer
    import nec_stack_sequencer_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           push_mask,
    input  logic [15:0]           pop_mask,
    input  logic [15:0]           sp_in,
    input  logic [15:0]           ss_in,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            reg_rd_sel,
    input  logic [15:0]           reg_rd_data,
    nec_stack_sequencer_if.master bus,
    output logic                  wb_valid,
    output logic [3:0]            wb_sel,
    output logic [15:0]           wb_data,
    output logic [15:0]           sp_out,
    output logic                  sp_we
);

    localparam logic [3:0] SP_IDX = 4'(STACK_SP_BIT);
    // Wide enough for {SS,4'b0}+SP; truncation to ADDR_W gives the wrap.
    localparam int SUM_W = (ADDR_W > 20) ? ADDR_W : 20;

    stack_seq_state_e state_q, state_d;
    logic [15:0] push_rem_q, push_rem_d;
    logic [15:0] pop_rem_q, pop_rem_d;
    logic [15:0] sp_q, sp_d;
    logic [15:0] sp_start_q, sp_start_d;
    logic [15:0] ss_q, ss_d;
    logic        mem_req_q, mem_req_d;
    logic        wb_valid_q, wb_valid_d;
    logic [3:0]  wb_sel_q, wb_sel_d;
    logic [15:0] wb_data_q, wb_data_d;

    logic [3:0]  push_idx, pop_idx;
    logic        push_any, pop_any;
    logic        ack;
    logic [15:0] eff_sp;
    logic [SUM_W-1:0] phys_sum;

    nec_mask_pick #(.LSB_FIRST(1'b1)) u_push_pick (
        .mask  (push_rem_q),
        .index (push_idx),
        .any   (push_any)
    );

    nec_mask_pick #(.LSB_FIRST(1'b0)) u_pop_pick (
        .mask  (pop_rem_q),
        .index (pop_idx),
        .any   (pop_any)
    );

    // An ack only counts against a request we are actually presenting.
    assign ack = bus.mem_ack && mem_req_q;

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SSQ_IDLE;
            push_rem_q <= '0;
            pop_rem_q  <= '0;
            sp_q       <= '0;
            sp_start_q <= '0;
            ss_q       <= '0;
            mem_req_q  <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_sel_q   <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            push_rem_q <= push_rem_d;
            pop_rem_q  <= pop_rem_d;
            sp_q       <= sp_d;
            sp_start_q <= sp_start_d;
            ss_q       <= ss_d;
            mem_req_q  <= mem_req_d;
            wb_valid_q <= wb_valid_d;
            wb_sel_q   <= wb_sel_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Next-state logic: on each ack retire the current item and move SP;
    // the phase ends when its remaining mask becomes empty.
    always_comb begin
        state_d    = state_q;
        push_rem_d = push_rem_q;
        pop_rem_d  = pop_rem_q;
        sp_d       = sp_q;
        sp_start_d = sp_start_q;
        ss_d       = ss_q;
        wb_valid_d = 1'b0;
        wb_sel_d   = wb_sel_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            SSQ_IDLE: begin
                if (start) begin
                    push_rem_d = push_mask;
                    pop_rem_d  = pop_mask;
                    sp_d       = sp_in;
                    sp_start_d = sp_in;
                    ss_d       = ss_in;
                    if (|push_mask)     state_d = SSQ_PUSH;
                    else if (|pop_mask) state_d = SSQ_POP;
                    else                state_d = SSQ_FIN;
                end
            end
            SSQ_PUSH: begin
                if (!push_any) begin
                    state_d = pop_any ? SSQ_POP : SSQ_FIN;
                end else if (ack) begin
                    push_rem_d = clear_bit(push_rem_q, push_idx);
                    sp_d       = sp_q - 16'd2;
                    if (push_rem_d == 16'h0000) state_d = pop_any ? SSQ_POP : SSQ_FIN;
                end
            end
            SSQ_POP: begin
                if (!pop_any) begin
                    state_d = SSQ_FIN;
                end else if (ack) begin
                    pop_rem_d  = clear_bit(pop_rem_q, pop_idx);
                    sp_d       = sp_q + 16'd2;
                    // A popped SP slot is discarded; SP itself is committed via sp_we.
                    wb_valid_d = (pop_idx != SP_IDX);
                    wb_sel_d   = pop_idx;
                    wb_data_d  = bus.mem_rdata;
                    if (pop_rem_d == 16'h0000) state_d = SSQ_FIN;
                end
            end
            SSQ_FIN: begin
                state_d = SSQ_IDLE;
            end
            default: begin
                state_d = SSQ_IDLE;
            end
        endcase

        mem_req_d = (state_d == SSQ_PUSH) || (state_d == SSQ_POP);
    end

    // Outputs. The bus fields derive only from registered state, so they
    // stay put for as long as a request waits for its ack.
    always_comb begin
        busy       = (state_q == SSQ_PUSH) || (state_q == SSQ_POP);
        done       = (state_q == SSQ_FIN);
        sp_we      = (state_q == SSQ_FIN);
        sp_out     = sp_q;
        wb_valid   = wb_valid_q;
        wb_sel     = wb_sel_q;
        wb_data    = wb_data_q;

        // Push writes below the current SP; pop reads at it.
        eff_sp     = (state_q == SSQ_PUSH) ? (sp_q - 16'd2) : sp_q;
        phys_sum   = SUM_W'({ss_q, 4'b0000}) + SUM_W'(eff_sp);

        bus.mem_req   = mem_req_q;
        bus.mem_wr    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        reg_rd_sel    = 4'd0;
        if (mem_req_q) begin
            bus.mem_addr = phys_sum[ADDR_W-1:0];
            if (state_q == SSQ_PUSH) begin
                bus.mem_wr    = 1'b1;
                reg_rd_sel    = push_idx;
                // The SP item stores the value SP had before the sequence began.
                bus.mem_wdata = (push_idx == SP_IDX) ? sp_start_q : reg_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_nec_stack_sequencer.sv
// tb_nec_stack_sequencer
// Scoreboard bench: each start pushes the expected bus transactions,
// writebacks and final SP into queues; a monitor on the falling edge pops
// and compares them as the DUT presents them. A responder process plays
// the BIU with a programmable ack delay.
module tb_nec_stack_sequencer;
    import nec_stack_sequencer_pkg::*;

    localparam int ADDR_W = 20;

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [3:0]  sel;
    } bus_exp_t;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] data;
    } wb_exp_t;

    typedef struct {
        logic [15:0] sp;
        bit          has_bus;
    } done_exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] push_mask, pop_mask, sp_in, ss_in;
    logic        busy, done, wb_valid, sp_we;
    logic [3:0]  reg_rd_sel, wb_sel;
    logic [15:0] reg_rd_data, wb_data, sp_out;
    logic [15:0] regfile [16];

    nec_stack_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    nec_stack_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .push_mask   (push_mask),
        .pop_mask    (pop_mask),
        .sp_in       (sp_in),
        .ss_in       (ss_in),
        .busy        (busy),
        .done        (done),
        .reg_rd_sel  (reg_rd_sel),
        .reg_rd_data (reg_rd_data),
        .bus         (bus),
        .wb_valid    (wb_valid),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .sp_out      (sp_out),
        .sp_we       (sp_we)
    );

    assign reg_rd_data = regfile[reg_rd_sel];

    bus_exp_t  exp_bus[$];
    wb_exp_t   exp_wb[$];
    done_exp_t exp_done[$];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_ack_cyc = 0;
    int ack_count = 0;
    int done_count = 0;
    int ack_delay = 0;
    bit spurious_ack_en = 0;
    bit first_req_pending = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory contents seen by pops: a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input logic [19:0] a);
        return 16'(a * 20'd7919) ^ 16'hA55A;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic flagFail(input string name, input logic [31:0] actual);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: actual=0x%0h expected=no such event (cycle %0d)", name, actual, cyc);
    endtask

    // BIU model: acks after ack_delay waiting cycles; optional stray acks while idle.
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                bus.mem_ack = 1'b0;
                cnt = 0;
            end else if (bus.mem_req) begin
                if (cnt >= ack_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    cnt = 0;
                end else begin
                    bus.mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                cnt = 0;
                bus.mem_ack   = spurious_ack_en && ($urandom_range(0, 2) == 0);
                bus.mem_rdata = 16'($urandom);
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the queue fronts.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (bus.mem_req) begin
                if (first_req_pending) begin
                    checkOutput("first_req_cycle", cyc, start_cyc + 1);
                    first_req_pending = 0;
                end
                checkOutput("busy_with_req", {31'b0, busy}, 32'd1);
                if (exp_bus.size() == 0) begin
                    flagFail("unexpected_req", bus.mem_addr);
                end else begin
                    checkOutput("mem_wr", {31'b0, bus.mem_wr}, {31'b0, exp_bus[0].wr});
                    checkOutput("mem_addr", bus.mem_addr, exp_bus[0].addr);
                    if (exp_bus[0].wr) begin
                        checkOutput("mem_wdata", bus.mem_wdata, exp_bus[0].wdata);
                        checkOutput("reg_rd_sel", reg_rd_sel, exp_bus[0].sel);
                    end
                    if (bus.mem_ack) void'(exp_bus.pop_front());
                end
                if (bus.mem_ack) begin
                    ack_count++;
                    last_ack_cyc = cyc;
                end
            end
            if (wb_valid) begin
                if (exp_wb.size() == 0) begin
                    flagFail("unexpected_wb", wb_sel);
                end else begin
                    wb_exp_t w;
                    w = exp_wb.pop_front();
                    checkOutput("wb_sel", wb_sel, w.sel);
                    checkOutput("wb_data", wb_data, w.data);
                end
            end
            if (done) begin
                done_count++;
                if (exp_done.size() == 0) begin
                    flagFail("unexpected_done", sp_out);
                end else begin
                    done_exp_t d;
                    d = exp_done.pop_front();
                    checkOutput("sp_out", sp_out, d.sp);
                    checkOutput("sp_we", {31'b0, sp_we}, 32'd1);
                    checkOutput("busy_at_done", {31'b0, busy}, 32'd0);
                    checkOutput("done_cycle", cyc, d.has_bus ? last_ack_cyc + 1 : start_cyc + 1);
                end
            end
        end
    end

    task automatic flushExpect();
        exp_bus.delete();
        exp_wb.delete();
        exp_done.delete();
        first_req_pending = 0;
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        flushExpect();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic fillRegfile(input bit rnd);
        for (int i = 0; i < 16; i++) regfile[i] = rnd ? 16'($urandom) : 16'(16'hA000 + i * 16'h0111);
    endtask

    // Reference model plus start pulse. Pushes go lowest index first and
    // predecrement SP; pops go highest index first and postincrement SP.
    task automatic applyStimulus(input logic [15:0] pm, input logic [15:0] om, input logic [15:0] sp,
                                 input logic [15:0] ss, input bit spurious, input bit wait_done);
        logic [15:0] sp_m;
        bit has_bus;
        int target;
        sp_m = sp;
        has_bus = (pm != 0) || (om != 0);
        for (int i = 0; i < 16; i++) begin
            if (pm[i]) begin
                bus_exp_t e;
                sp_m = sp_m - 16'd2;
                e.wr = 1;
                e.addr = 20'((int'(ss) * 16 + int'(sp_m)) % (1 << 20));
                e.wdata = (i == STACK_SP_BIT) ? sp : regfile[i];
                e.sel = 4'(i);
                exp_bus.push_back(e);
            end
        end
        for (int i = 15; i >= 0; i--) begin
            if (om[i]) begin
                bus_exp_t e;
                e.wr = 0;
                e.addr = 20'((int'(ss) * 16 + int'(sp_m)) % (1 << 20));
                e.wdata = 16'h0000;
                e.sel = 4'(i);
                exp_bus.push_back(e);
                if (i != STACK_SP_BIT) exp_wb.push_back('{sel: 4'(i), data: mem_word(e.addr)});
                sp_m = sp_m + 16'd2;
            end
        end
        exp_done.push_back('{sp: sp_m, has_bus: has_bus});
        target = done_count + 1;

        @(posedge clk);
        #1;
        start = 1'b1;
        push_mask = pm;
        pop_mask = om;
        sp_in = sp;
        ss_in = ss;
        start_cyc = cyc;
        first_req_pending = has_bus;
        @(posedge clk);
        #1;
        start = 1'b0;
        push_mask = 16'($urandom);
        pop_mask = 16'($urandom);
        sp_in = 16'($urandom);
        ss_in = 16'($urandom);
        if (wait_done) begin
            for (int k = 0; k < 600; k++) begin
                if (done_count >= target) break;
                @(posedge clk);
                #1;
                start = spurious && busy && ($urandom_range(0, 1) == 1);
                push_mask = 16'($urandom);
                pop_mask = 16'($urandom);
            end
            start = 1'b0;
            if (done_count < target) begin
                flagFail("done_timeout", done_count);
                doReset();
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int target;
        reset = 1'b1;
        start = 1'b0;
        push_mask = 16'h0000;
        pop_mask = 16'h0000;
        sp_in = 16'h0000;
        ss_in = 16'h0000;
        fillRegfile(0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("rst_mem_wr", {31'b0, bus.mem_wr}, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_reg_rd_sel", reg_rd_sel, 32'd0);
        checkOutput("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        checkOutput("rst_wb_sel", wb_sel, 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_sp_out", sp_out, 32'd0);
        checkOutput("rst_sp_we", {31'b0, sp_we}, 32'd0);
        reset = 1'b0;

        $display("[TB] case 1: PUSHA");
        applyStimulus(16'h00FF, 16'h0000, 16'h0100, 16'h2000, 0, 1);
        $display("[TB] case 2: interrupt frame with SP wrap");
        applyStimulus(16'h2600, 16'h0000, 16'h0004, 16'h0000, 0, 1);
        $display("[TB] case 3: POPA");
        applyStimulus(16'h0000, 16'h00FF, 16'h00F0, 16'h2000, 0, 1);
        $display("[TB] case 4: stalled acks with ignored starts");
        ack_delay = 5;
        fillRegfile(1);
        applyStimulus(16'h2613, 16'h0090, 16'h8000, 16'h1234, 1, 1);
        ack_delay = 0;
        $display("[TB] case 5: empty masks");
        applyStimulus(16'h0000, 16'h0000, 16'h1234, 16'h5555, 0, 1);

        $display("[TB] case 6: reset mid-sequence");
        fillRegfile(0);
        target = ack_count + 3;
        applyStimulus(16'h00FF, 16'h0000, 16'h0100, 16'h2000, 0, 0);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            if (ack_count >= target) break;
        end
        if (ack_count < target) flagFail("abort_ack_timeout", ack_count);
        #1;
        reset = 1'b1;
        flushExpect();
        #1;
        checkOutput("abort_mem_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(16'h0000, 16'h00FF, 16'h00F0, 16'h2000, 0, 1);

        $display("[TB] random sequences");
        spurious_ack_en = 1;
        for (int n = 0; n < 30; n++) begin
            logic [15:0] pm, om, sp;
            fillRegfile(1);
            pm = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            om = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            sp = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 6)) : 16'($urandom);
            ack_delay = $urandom_range(0, 3);
            applyStimulus(pm, om, sp, 16'($urandom), $urandom_range(0, 1) == 1, 1);
        end
        spurious_ack_en = 0;
        repeat (3) @(posedge clk);

        checkOutput("exp_bus_drained", exp_bus.size(), 32'd0);
        checkOutput("exp_wb_drained", exp_wb.size(), 32'd0);
        checkOutput("exp_done_drained", exp_done.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
